// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the hazard/forwarding scoreboard.
// The scoreboard entry's rd field is sized from DEF_NUM_REGS.
package riscv_pipe_pkg;

  localparam int DEF_XLEN     = 64;
  localparam int DEF_NUM_REGS = 32;
  localparam int REG_IDX_W    = $clog2(DEF_NUM_REGS);

  // Forward select value meaning "use the register-file read captured at issue"
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } sb_entry_t;

endpackage

// File: rtl/sb_src_match.sv
// Looks up one source register in the in-flight table.
// Returns the youngest matching writer, its stage index and whether it is a load.
module sb_src_match
  import riscv_pipe_pkg::*;
#(
  parameter  int EX_DEPTH = 3,
  parameter  int RAW      = REG_IDX_W,
  localparam int FW       = $clog2(EX_DEPTH)
) (
  input  sb_entry_t [EX_DEPTH-1:0] entries,
  input  logic [RAW-1:0]           src,
  input  logic                     used,
  output logic                     hit,
  output logic [FW-1:0]            idx,
  output logic                     is_load
);

  // Scan oldest to youngest so the lowest matching index is the one kept
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    if (used && (src != '0)) begin
      for (int k = EX_DEPTH - 1; k >= 0; k--) begin
        if (entries[k].valid && entries[k].regwrite &&
            (entries[k].rd == REG_IDX_W'(src))) begin
          hit     = 1'b1;
          idx     = FW'(k);
          is_load = entries[k].memread;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard and forwarding controller: tracks in-flight destinations, stalls ID on
// load-use, registers forward selects and muxes EX operands. Optional perf counters: SB_PERF_CNT_EN.
module pipe_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int EX_DEPTH   = 3,
  parameter int LOAD_READY = 2,
  localparam int RAW       = $clog2(NUM_REGS),
  localparam int FW        = $clog2(EX_DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [RAW-1:0]           id_rs1,
  input  logic [RAW-1:0]           id_rs2,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [RAW-1:0]           id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic [XLEN-1:0]          id_rs1_data,
  input  logic [XLEN-1:0]          id_rs2_data,
  input  logic                     flush,
  input  logic [EX_DEPTH*XLEN-1:0] stage_result,
  output logic                     id_stall,
  output logic [FW-1:0]            ex_fwd_a,
  output logic [FW-1:0]            ex_fwd_b,
  output logic [XLEN-1:0]          ex_op_a,
  output logic [XLEN-1:0]          ex_op_b
`ifdef SB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stalls,
  output logic [31:0]              perf_fwds
`endif
);

  sb_entry_t [EX_DEPTH-1:0] sb_table;
  sb_entry_t                new_entry;

  logic          hit_a, hit_b, load_a, load_b;
  logic [FW-1:0] idx_a, idx_b;
  logic [FW-1:0] sel_a_next, sel_b_next;
  logic          issue;
  logic [XLEN-1:0] op_a_q, op_b_q;

  sb_src_match #(.EX_DEPTH(EX_DEPTH), .RAW(RAW)) u_match_a (
    .entries (sb_table),
    .src     (id_rs1),
    .used    (id_rs1_used),
    .hit     (hit_a),
    .idx     (idx_a),
    .is_load (load_a)
  );

  sb_src_match #(.EX_DEPTH(EX_DEPTH), .RAW(RAW)) u_match_b (
    .entries (sb_table),
    .src     (id_rs2),
    .used    (id_rs2_used),
    .hit     (hit_b),
    .idx     (idx_b),
    .is_load (load_b)
  );

  // A load is unusable until it reaches LOAD_READY; flush still kills the ID slot
  always_comb begin
    id_stall = (hit_a && load_a && ((int'(idx_a) + 1) < LOAD_READY)) ||
               (hit_b && load_b && ((int'(idx_b) + 1) < LOAD_READY));
    issue    = id_valid && !id_stall && !flush;

    new_entry = '0;
    if (issue) begin
      new_entry.valid    = 1'b1;
      new_entry.rd       = REG_IDX_W'(id_rd);
      new_entry.regwrite = id_regwrite && (id_rd != '0);
      new_entry.memread  = id_memread;
    end

    // A producer leaving the table this edge has already written the write-through RF
    sel_a_next = FW'(FWD_RF);
    sel_b_next = FW'(FWD_RF);
    if (issue && hit_a && ((int'(idx_a) + 1) < EX_DEPTH)) sel_a_next = idx_a + 1'b1;
    if (issue && hit_b && ((int'(idx_b) + 1) < EX_DEPTH)) sel_b_next = idx_b + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_table <= '0;
      ex_fwd_a <= FW'(FWD_RF);
      ex_fwd_b <= FW'(FWD_RF);
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      sb_table[0] <= new_entry;
      for (int k = 1; k < EX_DEPTH; k++) begin
        sb_table[k] <= sb_table[k-1];
      end
      ex_fwd_a <= sel_a_next;
      ex_fwd_b <= sel_b_next;
      if (issue) begin
        op_a_q <= id_rs1_data;
        op_b_q <= id_rs2_data;
      end
    end
  end

  assign ex_op_a = (ex_fwd_a == FW'(FWD_RF)) ? op_a_q : stage_result[ex_fwd_a*XLEN +: XLEN];
  assign ex_op_b = (ex_fwd_b == FW'(FWD_RF)) ? op_b_q : stage_result[ex_fwd_b*XLEN +: XLEN];

`ifdef SB_PERF_CNT_EN
  logic [1:0] fwd_count;

  assign fwd_count = {1'b0, (sel_a_next != FW'(FWD_RF))} + {1'b0, (sel_b_next != FW'(FWD_RF))};

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stalls <= '0;
      perf_fwds   <= '0;
    end else begin
      if (id_stall && !flush && id_valid) perf_stalls <= perf_stalls + 32'd1;
      perf_fwds <= perf_fwds + 32'(fwd_count);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed and randomized bench for pipe_scoreboard against a history-queue model.
// Perf counter checks are compiled in when SB_PERF_CNT_EN is defined.
module tb_pipe_scoreboard;

  localparam int XLEN       = 64;
  localparam int EX_DEPTH   = 3;
  localparam int LOAD_READY = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     id_valid;
  logic [4:0]               id_rs1, id_rs2, id_rd;
  logic                     id_rs1_used, id_rs2_used;
  logic                     id_regwrite, id_memread;
  logic [XLEN-1:0]          id_rs1_data, id_rs2_data;
  logic                     flush;
  logic [EX_DEPTH*XLEN-1:0] stage_result;
  logic                     id_stall;
  logic [1:0]               ex_fwd_a, ex_fwd_b;
  logic [XLEN-1:0]          ex_op_a, ex_op_b;
`ifdef SB_PERF_CNT_EN
  logic [31:0]              perf_stalls, perf_fwds;
`endif

  pipe_scoreboard #(
    .XLEN(XLEN), .NUM_REGS(32), .EX_DEPTH(EX_DEPTH), .LOAD_READY(LOAD_READY)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .flush        (flush),
    .stage_result (stage_result),
    .id_stall     (id_stall),
    .ex_fwd_a     (ex_fwd_a),
    .ex_fwd_b     (ex_fwd_b),
    .ex_op_a      (ex_op_a),
    .ex_op_b      (ex_op_b)
`ifdef SB_PERF_CNT_EN
    ,
    .perf_stalls  (perf_stalls),
    .perf_fwds    (perf_fwds)
`endif
  );

  always #5 clock = ~clock;

  // Model: one record per cycle of what entered EX; index 0 is the newest
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } rec_t;

  rec_t            hist[$];
  int              m_sel_a, m_sel_b;
  logic [XLEN-1:0] m_cap_a, m_cap_b;
  int unsigned     m_perf_stalls, m_perf_fwds;
  bit              m_last_stall;
  int              checks = 0;
  int              errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                               input int rd, input bit rw, input bit mr, input bit fl);
    id_valid    = v;
    id_rs1      = 5'(rs1);
    id_rs2      = 5'(rs2);
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd       = 5'(rd);
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
    id_rs1_data = (rs1 == 0) ? 64'd0 : {$urandom, $urandom};
    id_rs2_data = (rs2 == 0) ? 64'd0 : {$urandom, $urandom};
    for (int k = 0; k < EX_DEPTH; k++) stage_result[k*XLEN +: XLEN] = {$urandom, $urandom};
  endtask

  function automatic bit modelFind(input int src, input bit used, output int age, output bit ld);
    age = 0;
    ld  = 1'b0;
    if (!used || src == 0) return 1'b0;
    foreach (hist[a]) begin
      if (hist[a].v && hist[a].wr && hist[a].rd == src) begin
        age = a;
        ld  = hist[a].ld;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit modelStall();
    int aa, ab;
    bit la, lb, ha, hb;
    ha = modelFind(int'(id_rs1), id_rs1_used, aa, la);
    hb = modelFind(int'(id_rs2), id_rs2_used, ab, lb);
    return (ha && la && aa + 1 < LOAD_READY) || (hb && lb && ab + 1 < LOAD_READY);
  endfunction

  function automatic void modelReset();
    hist.delete();
    m_sel_a = 0;
    m_sel_b = 0;
    m_cap_a = '0;
    m_cap_b = '0;
    m_perf_stalls = 0;
    m_perf_fwds   = 0;
  endfunction

  task automatic checkAll();
    logic [XLEN-1:0] exp_a, exp_b;
    #1;
    m_last_stall = modelStall();
    exp_a = (m_sel_a == 0) ? m_cap_a : stage_result[m_sel_a*XLEN +: XLEN];
    exp_b = (m_sel_b == 0) ? m_cap_b : stage_result[m_sel_b*XLEN +: XLEN];
    checkOutput("id_stall", id_stall, m_last_stall);
    checkOutput("ex_fwd_a", ex_fwd_a, m_sel_a);
    checkOutput("ex_fwd_b", ex_fwd_b, m_sel_b);
    checkOutput("ex_op_a", ex_op_a, exp_a);
    checkOutput("ex_op_b", ex_op_b, exp_b);
`ifdef SB_PERF_CNT_EN
    checkOutput("perf_stalls", perf_stalls, m_perf_stalls);
    checkOutput("perf_fwds", perf_fwds, m_perf_fwds);
`endif
  endtask

  task automatic advance();
    int   aa, ab, na, nb;
    bit   la, lb, ha, hb, st, iss;
    rec_t r;
    if (reset) begin
      @(posedge clock);
      modelReset();
      @(negedge clock);
      return;
    end
    ha  = modelFind(int'(id_rs1), id_rs1_used, aa, la);
    hb  = modelFind(int'(id_rs2), id_rs2_used, ab, lb);
    st  = modelStall();
    iss = id_valid && !st && !flush;
    na  = (iss && ha && aa + 1 < EX_DEPTH) ? aa + 1 : 0;
    nb  = (iss && hb && ab + 1 < EX_DEPTH) ? ab + 1 : 0;
    r.v  = iss;
    r.rd = int'(id_rd);
    r.wr = id_regwrite;
    r.ld = id_memread;
    @(posedge clock);
    if (st && !flush && id_valid) m_perf_stalls++;
    m_perf_fwds += ((na != 0) ? 1 : 0) + ((nb != 0) ? 1 : 0);
    m_sel_a = na;
    m_sel_b = nb;
    if (iss) begin
      m_cap_a = id_rs1_data;
      m_cap_b = id_rs2_data;
    end
    hist.push_front(r);
    if (hist.size() > EX_DEPTH) void'(hist.pop_back());
    @(negedge clock);
  endtask

  task automatic step();
    checkAll();
    advance();
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int rs1, rs2, rd;
    bit v, u1, u2, rw, mr;

    resetDut();

    // Reset state with an idle ID stage
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkAll();
    checkOutput("reset_stall", id_stall, 1'b0);
    checkOutput("reset_fwd_a", ex_fwd_a, 2'd0);
    checkOutput("reset_op_a", ex_op_a, 64'd0);
    advance();

    // ld x5 ; add x6,x5,x1 -> one stall, then forward from stage 2
    applyStimulus(1, 2, 1, 0, 0, 5, 1, 1, 0); step();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
    checkAll(); checkOutput("ld_use_stall", id_stall, 1'b1); advance();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
    checkAll(); checkOutput("ld_use_release", id_stall, 1'b0); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkAll();
    checkOutput("ld_use_fwd", ex_fwd_a, 2'd2);
    checkOutput("ld_use_op", ex_op_a, stage_result[2*XLEN +: XLEN]);
    advance();

    // add x6 ; sub x7,x6,x6 -> both operands from MEM
    applyStimulus(1, 1, 1, 2, 1, 6, 1, 0, 0); step();
    applyStimulus(1, 6, 1, 6, 1, 7, 1, 0, 0);
    checkAll(); checkOutput("alu_no_stall", id_stall, 1'b0); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkAll();
    checkOutput("alu_fwd_a", ex_fwd_a, 2'd1);
    checkOutput("alu_fwd_b", ex_fwd_b, 2'd1);
    checkOutput("alu_op_b", ex_op_b, stage_result[1*XLEN +: XLEN]);
    advance();

    // Two writers of x7: the younger one wins
    applyStimulus(1, 1, 1, 0, 0, 7, 1, 0, 0); step();
    applyStimulus(1, 2, 1, 0, 0, 7, 1, 0, 0); step();
    applyStimulus(1, 7, 1, 0, 0, 8, 1, 0, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkAll(); checkOutput("youngest_fwd", ex_fwd_a, 2'd1); advance();

    // Writes to x0 are never forwarded
    applyStimulus(1, 1, 1, 2, 1, 0, 1, 0, 0); step();
    applyStimulus(1, 0, 1, 0, 0, 9, 1, 0, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkAll();
    checkOutput("x0_fwd", ex_fwd_a, 2'd0);
    checkOutput("x0_op", ex_op_a, 64'd0);
    advance();

    // Load-use with flush in the same cycle: bubble, no stall counted
    applyStimulus(1, 1, 1, 0, 0, 9, 1, 1, 0); step();
    applyStimulus(1, 9, 1, 0, 0, 10, 1, 0, 1);
    checkAll(); checkOutput("flush_stall", id_stall, 1'b1); advance();
    applyStimulus(1, 9, 1, 0, 0, 10, 1, 0, 0);
    checkAll(); checkOutput("flush_bubble_fwd", ex_fwd_a, 2'd0); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Reset asserted while a load-use stall is pending
    applyStimulus(1, 1, 1, 0, 0, 11, 1, 1, 0); step();
    applyStimulus(1, 11, 1, 0, 0, 12, 1, 0, 0);
    checkAll(); checkOutput("pre_reset_stall", id_stall, 1'b1);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    checkAll();
    checkOutput("mid_reset_stall", id_stall, 1'b0);
    checkOutput("mid_reset_fwd_a", ex_fwd_a, 2'd0);
    checkOutput("mid_reset_fwd_b", ex_fwd_b, 2'd0);
`ifdef SB_PERF_CNT_EN
    checkOutput("mid_reset_perf_stalls", perf_stalls, 32'd0);
    checkOutput("mid_reset_perf_fwds", perf_fwds, 32'd0);
`endif
    advance();

    // Randomized traffic on a small register window to provoke hazards
    rs1 = 0; rs2 = 0; rd = 0; v = 0; u1 = 0; u2 = 0; rw = 0; mr = 0;
    for (int n = 0; n < 500; n++) begin
      if (!(m_last_stall && v)) begin
        v   = ($urandom_range(9) != 0);
        rs1 = $urandom_range(7);
        rs2 = $urandom_range(7);
        u1  = ($urandom_range(4) != 0);
        u2  = ($urandom_range(4) != 0);
        rd  = $urandom_range(7);
        rw  = ($urandom_range(4) != 0);
        mr  = rw && ($urandom_range(2) == 0);
      end
      applyStimulus(v, rs1, u1, rs2, u2, rd, rw, mr, $urandom_range(11) == 0);
      reset = ($urandom_range(99) == 0);
      step();
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
